// File: rtl/rr_arb.sv
// Round-robin arbiter with a registered, sticky one-hot grant.
// The grant is held until the consumer acks it.
// On an ack, priority moves to the requester after the winner, and a new
// winner is loaded on the same edge, so back-to-back grants have no bubble.
// o_gnt drives a one-hot AND-OR mux select directly.

module rr_arb #(
   parameter  int unsigned N     = 4,
   localparam int unsigned ENC_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic [N-1:0]     i_req,
   input  logic             i_ack,
   output logic [N-1:0]     o_gnt,
   output logic             o_gnt_vld,
   output logic [ENC_W-1:0] o_gnt_enc
);

   typedef enum logic [0:0] {StIdle, StGranted} state_e;

   state_e           state_q;
   logic [N-1:0]     gnt_q;
   logic             vld_q;
   logic [ENC_W-1:0] enc_q;
   logic [ENC_W-1:0] ptr_q;

   // Pointer value once the current winner is accepted; explicit wrap for non-power-of-two N
   logic [ENC_W-1:0] ptr_after;
   always_comb begin
      ptr_after = enc_q + 1'b1;
      if (enc_q == ENC_W'(N - 1)) begin
         ptr_after = '0;
      end
   end

   // Select scan origin and candidate set: from ptr when idle, from winner+1 with winner masked on ack
   logic [ENC_W-1:0] scan_start;
   logic [N-1:0]     scan_req;
   always_comb begin
      scan_start = ptr_q;
      scan_req   = i_req;
      if (state_q == StGranted) begin
         scan_start = ptr_after;
         scan_req   = i_req & ~gnt_q;
      end
   end

   // Circular first-set-bit search starting at scan_start
   logic             scan_hit;
   logic [ENC_W-1:0] scan_idx;
   logic [N-1:0]     scan_onehot;
   int unsigned      scan_pos;
   logic [N-1:0]     scan_shift;
   always_comb begin
      scan_hit    = 1'b0;
      scan_idx    = '0;
      scan_onehot = '0;
      scan_pos    = 0;
      scan_shift  = '0;
      for (int unsigned k = 0; k < N; k++) begin
         scan_pos = 32'(scan_start) + k;
         if (scan_pos >= N) begin
            scan_pos = scan_pos - N;
         end
         scan_shift = scan_req >> scan_pos;
         if (!scan_hit && scan_shift[0]) begin
            scan_hit    = 1'b1;
            scan_idx    = ENC_W'(scan_pos);
            scan_onehot = N'(1) << scan_pos;
         end
      end
   end

   // The current winner still requesting: used to re-grant a lone requester after its ack
   logic own_hit;
   always_comb begin
      own_hit = |(i_req & gnt_q);
   end

   // Grant FSM; all outputs registered
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q <= StIdle;
         gnt_q   <= '0;
         vld_q   <= 1'b0;
         enc_q   <= '0;
         ptr_q   <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               // Acks while idle carry no meaning and are ignored
               if (scan_hit) begin
                  state_q <= StGranted;
                  gnt_q   <= scan_onehot;
                  vld_q   <= 1'b1;
                  enc_q   <= scan_idx;
               end
            end
            StGranted: begin
               // Without an ack the grant is sticky even if requests change
               if (i_ack) begin
                  ptr_q <= ptr_after;
                  if (scan_hit) begin
                     gnt_q <= scan_onehot;
                     enc_q <= scan_idx;
                  end else if (!own_hit) begin
                     state_q <= StIdle;
                     gnt_q   <= '0;
                     vld_q   <= 1'b0;
                     enc_q   <= '0;
                  end
               end
            end
            default: begin
               state_q <= StIdle;
               gnt_q   <= '0;
               vld_q   <= 1'b0;
               enc_q   <= '0;
            end
         endcase
      end
   end

   assign o_gnt     = gnt_q;
   assign o_gnt_vld = vld_q;
   assign o_gnt_enc = enc_q;

   // Structural invariants of the registered grant
   a_onehot : assert property (@(posedge clk) disable iff (!arst_n) $onehot0(gnt_q));
   a_vld    : assert property (@(posedge clk) disable iff (!arst_n) vld_q == (|gnt_q));
   a_enc    : assert property (@(posedge clk) disable iff (!arst_n)
                               vld_q ? (gnt_q == (N'(1) << enc_q)) : (enc_q == '0));
   a_sticky : assert property (@(posedge clk) disable iff (!arst_n)
                               (vld_q && !i_ack) |=> $stable(gnt_q));

endmodule
